fc_layer_sequencer: RTL and testbench

Control FSM that runs one fully-connected layer on the shared single-neuron ALU. On `start` it:
- clears the ALU;
- fetches the input vector once;
- for each of `OUT_SZ` output neurons, fetches that neuron's weight row and bias, waits for the adder chain to settle, and emits the (optionally ReLU'd) result on a valid/ready stream.

It sits between the layer's weight/activation memory, the ALU, and the next layer's input buffer; row data travels directly from memory to the ALU, so this block carries only control and the result word.

---
 rtl/fc_layer_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer
//
// Control FSM that runs one fully-connected layer on a shared single-neuron
// ALU. After start it clears the ALU and fetches the input vector once. Then,
// for each output neuron, it fetches that neuron's weight row and bias, lets
// the adder chain settle, and emits the (optionally ReLU'd) result on a
// valid/ready stream. Row data goes straight from memory to the ALU, so this
// block only carries control signals and the result word.
//
// Ports
//   clk, rst_n        clock / asynchronous active-low reset
//   start             begin a layer (only sampled in IDLE)
//   busy, done        layer in progress / one-cycle completion pulse
//   rd_req, rd_sel,   memory read handshake: sel 0 = input vector,
//   rd_row, rd_valid    sel 1 = weight row + bias of neuron rd_row
//   alu_load_enable   0 = load values, 1 = load bias/weights, 2 = hold
//   alu_clear         ALU clear
//   alu_value         ALU result (combinational from the ALU registers)
//   out_valid/ready,  result stream towards the next layer's input buffer
//   out_data, out_index
// ---------------------------------------------------------------------------
module fc_layer_sequencer #(
  parameter int SIZE          = 16,
  parameter int OUT_SZ        = 84,
  parameter int SETTLE_CYCLES = 2,
  parameter int RELU          = 1,
  localparam int ROW_W        = (OUT_SZ > 1) ? $clog2(OUT_SZ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_req,
  output logic             rd_sel,
  output logic [ROW_W-1:0] rd_row,
  input  logic             rd_valid,
  output logic [1:0]       alu_load_enable,
  output logic             alu_clear,
  input  logic [SIZE-1:0]  alu_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_data,
  output logic [ROW_W-1:0] out_index
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] LD_VALUES = 2'd0;
  localparam logic [1:0] LD_BIAS_W = 2'd1;
  localparam logic [1:0] LD_HOLD   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_REQ_IN, S_LOAD_IN, S_REQ_W,
    S_LOAD_W, S_SETTLE, S_WRITE, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SIZE-1:0]  out_data_q, out_data_d;
  logic [ROW_W-1:0] out_index_q, out_index_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_req_q, rd_req_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       lae_q, lae_d;
  logic             alu_clear_q, alu_clear_d;
  logic [SIZE-1:0]  result;

  // Negative sums are clamped to zero when ReLU is enabled.
  assign result = ((RELU != 0) && alu_value[SIZE-1]) ? '0 : alu_value;

  always_comb begin
    // NOTE: every signal gets a default before the case statement so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;

    unique case (state_q)
      S_IDLE:    if (start) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_REQ_IN;
      S_REQ_IN:  if (rd_valid) state_d = S_LOAD_IN;
      S_LOAD_IN: begin
        row_d   = '0;
        state_d = S_REQ_W;
      end
      S_REQ_W:   if (rd_valid) state_d = S_LOAD_W;
      S_LOAD_W: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          out_data_d  = result;
          out_index_d = row_q;
          out_valid_d = 1'b1;
          state_d     = S_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (row_q == ROW_W'(OUT_SZ - 1)) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_REQ_W;
          end
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up with state_q without any combinational path to the ports.
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    rd_req_d    = (state_d == S_REQ_IN) || (state_d == S_REQ_W);
    rd_sel_d    = (state_d == S_REQ_W);
    alu_clear_d = (state_d == S_CLEAR);
    // The ALU loads values whenever it sees 0, so 0 is confined to LOAD_IN.
    lae_d = (state_d == S_LOAD_IN) ? LD_VALUES :
            (state_d == S_LOAD_W)  ? LD_BIAS_W : LD_HOLD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      lae_q       <= LD_HOLD;
      alu_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_req_q    <= rd_req_d;
      rd_sel_q    <= rd_sel_d;
      lae_q       <= lae_d;
      alu_clear_q <= alu_clear_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rd_req          = rd_req_q;
  assign rd_sel          = rd_sel_q;
  assign rd_row          = row_q;
  assign alu_load_enable = lae_q;
  assign alu_clear       = alu_clear_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_index       = out_index_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fc_layer_sequencer
//
// Two sequencers (ReLU on / ReLU off) share all inputs. The bench plays the
// memory (configurable request latency, optional stray rd_valid pulses) and
// the ALU (captures the row's preset sum on each bias/weight load), and
// drives out_ready with optional stalls. Each layer's expected transfers are
// simply "row r carries f(vals[r]) with index r, in order", and the expected
// layer length follows from the per-phase cycle counts.
// ---------------------------------------------------------------------------
module tb_fc_layer_sequencer;

  localparam int SIZE   = 16;
  localparam int OUT_SZ = 3;
  localparam int SETTLE = 2;
  localparam int ROW_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             rd_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [SIZE-1:0]  alu_value = '0;

  logic             a_busy, a_done, a_rd_req, a_rd_sel, a_alu_clear, a_out_valid;
  logic [ROW_W-1:0] a_rd_row, a_out_index;
  logic [1:0]       a_lae;
  logic [SIZE-1:0]  a_out_data;
  logic             b_busy, b_done, b_rd_req, b_rd_sel, b_alu_clear, b_out_valid;
  logic [ROW_W-1:0] b_rd_row, b_out_index;
  logic [1:0]       b_lae;
  logic [SIZE-1:0]  b_out_data;

  fc_layer_sequencer #(.SIZE(SIZE), .OUT_SZ(OUT_SZ), .SETTLE_CYCLES(SETTLE), .RELU(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(a_busy), .done(a_done),
    .rd_req(a_rd_req), .rd_sel(a_rd_sel), .rd_row(a_rd_row), .rd_valid(rd_valid),
    .alu_load_enable(a_lae), .alu_clear(a_alu_clear), .alu_value(alu_value),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_index(a_out_index)
  );

  fc_layer_sequencer #(.SIZE(SIZE), .OUT_SZ(OUT_SZ), .SETTLE_CYCLES(SETTLE), .RELU(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(b_busy), .done(b_done),
    .rd_req(b_rd_req), .rd_sel(b_rd_sel), .rd_row(b_rd_row), .rd_valid(rd_valid),
    .alu_load_enable(b_lae), .alu_clear(b_alu_clear), .alu_value(alu_value),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_index(b_out_index)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] ref_f(input logic [SIZE-1:0] v, input bit relu);
    return (relu && (v >= 16'h8000)) ? 16'h0000 : v;
  endfunction

  // Per-layer environment settings and observations.
  logic [SIZE-1:0] vals [OUT_SZ];
  int  lat, stall_row, stall_left, mem_cnt, req_run;
  bit  rand_ready, noise;
  int  n_load0, n_load1, n_clear;
  logic [SIZE-1:0] obs_a[$], obs_b[$];
  int  idx_a[$], idx_b[$];
  logic            prev_req, prev_valid, prev_ready;
  logic [ROW_W-1:0] prev_row, prev_index;
  logic [SIZE-1:0] prev_data;

  // One bench cycle, called right after a negedge: ALU, memory, stream.
  task automatic step();
    // ALU: captures on the negedge of the cycle its control is asserted.
    if (a_alu_clear) begin
      alu_value = '0;
      n_clear++;
    end
    if (a_lae == 2'd0) n_load0++;
    if (a_lae == 2'd1) begin
      n_load1++;
      alu_value = vals[a_rd_row];
    end
    check("lae_legal", a_lae <= 2'd2, 1);
    check("b_lae_match", b_lae, a_lae);

    // Memory: rd_valid after the request has been up for 'lat' cycles.
    if (a_rd_req) begin
      if (prev_req) check("rd_row_stable", a_rd_row, prev_row);
      req_run++;
      mem_cnt++;
      rd_valid = (mem_cnt >= lat);
    end else begin
      if (prev_req) check("rd_req_len", req_run, lat);
      req_run  = 0;
      mem_cnt  = 0;
      rd_valid = noise && ($urandom_range(0, 2) == 0);
    end
    start = noise && a_busy && ($urandom_range(0, 3) == 0);

    // Output stream.
    if (a_out_valid) check("no_req_in_write", a_rd_req, 0);
    if (a_out_valid && prev_valid && !prev_ready) begin
      check("stall_data", a_out_data, prev_data);
      check("stall_index", a_out_index, prev_index);
    end
    check("b_valid_match", b_out_valid, a_out_valid);
    if (a_out_valid && a_out_index == ROW_W'(stall_row) && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (a_out_valid && out_ready) begin
      obs_a.push_back(a_out_data);
      idx_a.push_back(int'(a_out_index));
      obs_b.push_back(b_out_data);
      idx_b.push_back(int'(b_out_index));
    end

    prev_req   = a_rd_req;
    prev_row   = a_rd_row;
    prev_valid = a_out_valid;
    prev_ready = out_ready;
    prev_data  = a_out_data;
    prev_index = a_out_index;
  endtask

  task automatic setup(input int lat_i, input int srow, input int slen,
                       input bit rr, input bit nz);
    lat = lat_i; stall_row = srow; stall_left = slen; rand_ready = rr; noise = nz;
    mem_cnt = 0; req_run = 0; n_load0 = 0; n_load1 = 0; n_clear = 0;
    prev_req = 0; prev_valid = 0; prev_ready = 0; prev_row = '0;
    prev_index = '0; prev_data = '0;
    obs_a.delete(); obs_b.delete(); idx_a.delete(); idx_b.delete();
  endtask

  // Runs one layer; cycles = index of the done cycle (0 = CLEAR cycle).
  task automatic run_layer(input int lat_i, input int srow, input int slen,
                           input bit rr, input bit nz, output int cycles);
    int cyc;
    setup(lat_i, srow, slen, rr, nz);
    cycles = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (cyc = 0; cyc < 2000; cyc++) begin
      step();
      if (a_done) begin
        cycles = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; rd_valid = 1'b0; out_ready = 1'b0;
    if (cycles < 0) check("done_timeout", 0, 1);
    check("b_done_match", b_done, a_done);
    @(negedge clk);
    check("done_pulse_len", a_done, 0);
    check("idle_after_done", a_busy, 0);
    // Scoreboard: one transfer per row, in row order.
    check("xfer_count_a", obs_a.size(), OUT_SZ);
    check("xfer_count_b", obs_b.size(), OUT_SZ);
    for (int r = 0; r < OUT_SZ && r < obs_a.size() && r < obs_b.size(); r++) begin
      check($sformatf("data_relu_r%0d", r), obs_a[r], ref_f(vals[r], 1'b1));
      check($sformatf("data_pass_r%0d", r), obs_b[r], ref_f(vals[r], 1'b0));
      check($sformatf("index_a_r%0d", r), idx_a[r], r);
      check($sformatf("index_b_r%0d", r), idx_b[r], r);
    end
    check("load_values_pulses", n_load0, 1);
    check("load_bias_pulses", n_load1, OUT_SZ);
    check("clear_pulses", n_clear, 1);
  endtask

  // Starts a layer and pulls reset either in the first SETTLE cycle or while
  // a result is being held in WRITE.
  task automatic abort_test(input bit in_write);
    bit hit;
    hit = 0;
    setup(1, 0, in_write ? 100 : 0, 1'b0, 1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (!in_write && a_lae == 2'd1) begin
        @(negedge clk);
        hit = 1;
      end else if (in_write && a_out_valid) begin
        hit = 1;
      end else begin
        step();
        @(negedge clk);
      end
    end
    check(in_write ? "abort_reached_write" : "abort_reached_settle", hit, 1);
    out_ready = 1'b0; rd_valid = 1'b0;
    if (in_write) check("abort_valid_before", a_out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", a_out_valid, 0);
    check("abort_busy", a_busy, 0);
    check("abort_lae", a_lae, 2);
    check("abort_rd_req", a_rd_req, 0);
    check("abort_rd_row", a_rd_row, 0);
    @(negedge clk);
    check("abort_no_done", a_done, 0);
    check("abort_out_data", a_out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_stays_idle", a_busy, 0);
  endtask

  initial begin
    int cyc;
    lat = 1; noise = 0; rand_ready = 0; stall_left = 0; stall_row = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_lae", a_lae, 2);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_rd_req", a_rd_req, 0);
    check("rst_alu_clear", a_alu_clear, 0);
    check("rst_out_data", a_out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimum-latency layer: 1 + 2 + 5*3 + 1 cycles, done in cycle 18.
    vals[0] = 16'd100; vals[1] = 16'd200; vals[2] = 16'd300;
    run_layer(1, 0, 0, 1'b0, 1'b0, cyc);
    check("min_layer_done_cycle", cyc, 18);

    // ReLU clamp vs pass-through.
    vals[0] = 16'hFF00; vals[1] = 16'h0005; vals[2] = 16'h8000;
    run_layer(1, 0, 0, 1'b0, 1'b0, cyc);
    check("relu_layer_done_cycle", cyc, 18);

    // 4-cycle memory latency on each of the 4 requests.
    for (int r = 0; r < OUT_SZ; r++) vals[r] = 16'($urandom);
    run_layer(4, 0, 0, 1'b0, 1'b0, cyc);
    check("latency_done_cycle", cyc, 18 + 4 * 3);

    // Row 1 stalled 7 cycles by out_ready.
    for (int r = 0; r < OUT_SZ; r++) vals[r] = 16'($urandom);
    run_layer(1, 1, 7, 1'b0, 1'b0, cyc);
    check("stall_done_cycle", cyc, 18 + 7);

    // Stray start / rd_valid pulses change nothing.
    for (int r = 0; r < OUT_SZ; r++) vals[r] = 16'($urandom);
    run_layer(1, 0, 0, 1'b0, 1'b1, cyc);
    check("noise_done_cycle", cyc, 18);

    // Randomized layers.
    for (int k = 0; k < 8; k++) begin
      int l;
      l = $urandom_range(1, 5);
      for (int r = 0; r < OUT_SZ; r++) vals[r] = 16'($urandom);
      run_layer(l, $urandom_range(0, OUT_SZ - 1), $urandom_range(0, 6), 1'b1, 1'b1, cyc);
      check("rand_done_min", cyc >= 18 + 4 * (l - 1), 1);
    end

    abort_test(1'b0);
    abort_test(1'b1);

    // Recovery after abort.
    vals[0] = 16'h7FFF; vals[1] = 16'h8001; vals[2] = 16'h0000;
    run_layer(1, 0, 0, 1'b0, 1'b0, cyc);
    check("recover_done_cycle", cyc, 18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
